// File: rtl/pc.sv
// Program counter for the ECU datapath.
// Holds a 16-bit address that can be loaded from the address-in bus,
// incremented, or have its upper byte cleared. The value goes onto a
// shared tri-state address bus and a small status vector feeds the
// control sequencer.
module pc (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ai,
  input  logic        lrc,
  input  logic        ini,
  input  logic        cub,
  input  logic        oe,
  output logic [15:0] ao,
  output logic [2:0]  is
);

  // Only one control acts per edge, so the controls are reduced to a
  // single operation code before the next-state logic looks at them.
  typedef enum logic [2:0] {
    OP_HOLD  = 3'd0,
    OP_RESET = 3'd1,
    OP_LOAD  = 3'd2,
    OP_CLEAR = 3'd3,
    OP_INC   = 3'd4
  } op_t;

  // Power-up values match the reset values so status is sane before the
  // first reset arrives.
  logic [15:0] r_pc   = 16'h0000;
  logic        r_wrap = 1'b0;

  op_t         w_op;
  logic [15:0] w_pcNext;
  logic        w_wrapNext;
  logic [15:0] w_pcInc;
  logic        w_carry;

  // The carry out of the incrementer is exactly the "old value was FFFF" case.
  assign {w_carry, w_pcInc} = {1'b0, r_pc} + 17'd1;

  // Priority encode the controls: reset beats load beats clear beats increment.
  always_comb begin
    w_op = OP_HOLD;
    if (rst) begin
      w_op = OP_RESET;
    end else if (lrc) begin
      w_op = OP_LOAD;
    end else if (cub) begin
      w_op = OP_CLEAR;
    end else if (ini) begin
      w_op = OP_INC;
    end
  end

  // Next value of the counter and wrap flag for the selected operation.
  always_comb begin
    w_pcNext   = r_pc;
    w_wrapNext = r_wrap;
    case (w_op)
      OP_RESET: begin
        w_pcNext   = 16'h0000;
        w_wrapNext = 1'b0;
      end
      OP_LOAD: begin
        w_pcNext   = ai;
        w_wrapNext = 1'b0;
      end
      OP_CLEAR: begin
        w_pcNext   = {8'h00, r_pc[7:0]};
        w_wrapNext = 1'b0;
      end
      OP_INC: begin
        w_pcNext   = w_pcInc;
        w_wrapNext = w_carry;
      end
      default: begin
        w_pcNext   = r_pc;
        w_wrapNext = r_wrap;
      end
    endcase
  end

  // Counter and wrap flag registers; reset is folded into the next-state
  // logic so it is sampled synchronously like every other control.
  always_ff @(posedge clk) begin
    r_pc   <= w_pcNext;
    r_wrap <= w_wrapNext;
  end

  // Bus and status come straight from the registers, so control inputs
  // have no combinational path to them and oe only gates the bus driver.
  assign ao = oe ? r_pc : {16{1'bz}};
  assign is = {r_pc[15], r_wrap, (r_pc == 16'h0000)};

endmodule

// File: tb/tb_pc.sv
// Directed testbench for the program counter.
// Each step drives controls away from the clock edge, lets one rising edge
// capture them, and then compares the bus and status against hand-computed
// values.
module tb_pc;

  logic        clk;
  logic        rst;
  logic [15:0] ai;
  logic        lrc;
  logic        ini;
  logic        cub;
  logic        oe;
  wire  [15:0] ao;
  logic [2:0]  is;

  int checks = 0;
  int errors = 0;

  // Released bus lines are pulled high, so a floating bus reads as FFFF.
  localparam logic [15:0] BUS_FLOAT = 16'hFFFF;

  pc dut (
    .clk (clk),
    .rst (rst),
    .ai  (ai),
    .lrc (lrc),
    .ini (ini),
    .cub (cub),
    .oe  (oe),
    .ao  (ao),
    .is  (is)
  );

  // Weak pull-ups make the high-impedance state of the bus observable.
  genvar g;
  generate
    for (g = 0; g < 16; g++) begin : gPull
      pullup (ao[g]);
    end
  endgenerate

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one set of controls for exactly one rising edge, then release them.
  task automatic applyStimulus(input logic r, input logic l, input logic i,
                               input logic c, input logic [15:0] a);
    @(negedge clk);
    rst = r;
    lrc = l;
    ini = i;
    cub = c;
    ai  = a;
    @(posedge clk);
    #1;
    rst = 1'b0;
    lrc = 1'b0;
    ini = 1'b0;
    cub = 1'b0;
  endtask

  task automatic checkBoth(input string tag, input logic [15:0] expAo,
                           input logic [2:0] expIs);
    checkOutput({tag, ".ao"}, ao, expAo);
    checkOutput({tag, ".is"}, {13'd0, is}, {13'd0, expIs});
  endtask

  initial begin
    rst = 1'b0;
    lrc = 1'b0;
    ini = 1'b0;
    cub = 1'b0;
    ai  = 16'h0000;
    oe  = 1'b1;

    #2;
    checkBoth("powerup", 16'h0000, 3'b001);

    applyStimulus(1, 0, 0, 0, 16'h0000);
    checkBoth("reset", 16'h0000, 3'b001);

    oe = 1'b0;
    #1;
    checkBoth("reset_oe0", BUS_FLOAT, 3'b001);
    oe = 1'b1;
    #1;

    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkBoth("inc1", 16'h0001, 3'b000);

    for (int k = 0; k < 4; k++) applyStimulus(0, 0, 1, 0, 16'h0000);
    checkBoth("inc_held4", 16'h0005, 3'b000);

    applyStimulus(0, 1, 0, 0, 16'h800A);
    checkBoth("load800A", 16'h800A, 3'b100);

    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkBoth("inc800B", 16'h800B, 3'b100);

    applyStimulus(0, 1, 0, 0, 16'h800A);
    applyStimulus(0, 0, 0, 1, 16'h0000);
    checkBoth("cub", 16'h000A, 3'b000);

    oe = 1'b0;
    #1;
    checkOutput("oe_off.ao", ao, BUS_FLOAT);
    applyStimulus(0, 0, 0, 0, 16'h0000);
    oe = 1'b1;
    #1;
    checkBoth("oe_back", 16'h000A, 3'b000);

    applyStimulus(0, 1, 0, 0, 16'hFFFF);
    checkBoth("loadFFFF", 16'hFFFF, 3'b100);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkBoth("wrap", 16'h0000, 3'b011);

    applyStimulus(0, 0, 0, 0, 16'h0000);
    checkBoth("wrap_hold", 16'h0000, 3'b011);

    applyStimulus(0, 0, 1, 0, 16'h0000);
    checkBoth("after_wrap", 16'h0001, 3'b000);

    applyStimulus(0, 1, 0, 0, 16'hFFFF);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    applyStimulus(0, 0, 0, 1, 16'h0000);
    checkBoth("cub_clears_c", 16'h0000, 3'b001);

    applyStimulus(0, 1, 0, 0, 16'hFFFF);
    applyStimulus(0, 0, 1, 0, 16'h0000);
    applyStimulus(0, 1, 1, 0, 16'h1234);
    checkBoth("lrc_ini", 16'h1234, 3'b000);

    applyStimulus(0, 0, 0, 0, 16'h5555);
    checkBoth("idle_hold", 16'h1234, 3'b000);

    applyStimulus(0, 1, 0, 0, 16'h12FF);
    applyStimulus(0, 0, 1, 1, 16'h0000);
    checkBoth("cub_ini", 16'h00FF, 3'b000);

    applyStimulus(1, 1, 0, 0, 16'hABCD);
    checkBoth("rst_lrc", 16'h0000, 3'b001);

    applyStimulus(0, 1, 0, 0, 16'h8001);
    applyStimulus(1, 0, 1, 1, 16'h0000);
    checkBoth("rst_all", 16'h0000, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends even if the clocking above stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
